// File: rtl/divider_pkg.sv
// divider_pkg: shared FSM encoding and sizing helper for the sequential divider
package divider_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DIV_W = 3;

    function automatic int cnt_w(input int w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle between a requester and the divider
interface seq_divider_if #(parameter int W = 3);

    logic           start;
    logic [2*W-1:0] num1;
    logic [W-1:0]   num2;
    logic           busy;
    logic           done;
    logic [2*W-1:0] quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;

    modport master (
        output start, num1, num2,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, num1, num2,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division step (shift in a dividend bit, trial subtract)
module div_step #(parameter int W = 3) (
    input  logic [W:0]   pr_in,
    input  logic         in_bit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   pr_out,
    output logic         qbit
);

    logic [W:0] sh;

    // pr_in[W] set means the shifted value exceeds W+1 bits, so it is certainly >= divisor
    always_comb begin
        sh     = {pr_in[W-1:0], in_bit};
        qbit   = pr_in[W] | (sh >= {1'b0, divisor});
        pr_out = qbit ? sh - {1'b0, divisor} : sh;
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock
module seq_divider
    import divider_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);

    localparam int CNT_W = cnt_w(W);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   dvd_q, dvd_d;
    logic [W-1:0]     dvs_q, dvs_d;
    logic [W:0]       pr_q, pr_d;
    logic [2*W-1:0]   quot_q, quot_d;
    logic [W-1:0]     rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [W:0]       pr_nx;
    logic             qbit;

    div_step #(.W(W)) u_step (
        .pr_in   (pr_q),
        .in_bit  (dvd_q[2*W-1]),
        .divisor (dvs_q),
        .pr_out  (pr_nx),
        .qbit    (qbit)
    );

    // Next-state: the dividend register doubles as the quotient register, quotient bits fill in from the LSB
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        if (state_q == CALC) begin
            dvd_d = {dvd_q[2*W-2:0], qbit};
            pr_d  = pr_nx;
            cnt_d = cnt_q + 1'b1;
            if (dvs_q == '0) begin
                state_d = DONE;
                quot_d  = '1;
                rem_d   = '0;
                dbz_d   = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else if (cnt_q == CNT_W'(2*W-1)) begin
                state_d = DONE;
                quot_d  = {dvd_q[2*W-2:0], qbit};
                rem_d   = pr_nx[W-1:0];
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end else if (bus.start) begin
            state_d = CALC;
            cnt_d   = '0;
            dvd_d   = bus.num1;
            dvs_d   = bus.num2;
            pr_d    = '0;
            busy_d  = 1'b1;
            dbz_d   = 1'b0;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // State and result registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vector bench for seq_divider
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    seq_divider_if #(.W(3)) bus ();

    seq_divider #(.W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] a;
        logic [2:0] b;
        logic [5:0] q;
        logic [2:0] r;
        logic       dbz;
        int         lat;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // issue a start at a falling edge; returns at the falling edge after the accept edge
    task automatic start_op(input logic [5:0] a, input logic [2:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.num1  = a;
        bus.num2  = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.num1  = 6'($urandom);
        bus.num2  = 3'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int seen;

    initial begin
        bus.start = 1'b0;
        bus.num1  = '0;
        bus.num2  = '0;
        vecs[0] = '{6'd30, 3'd5, 6'd6,  3'd0, 1'b0, 6};
        vecs[1] = '{6'd63, 3'd5, 6'd12, 3'd3, 1'b0, 6};
        vecs[2] = '{6'd49, 3'd7, 6'd7,  3'd0, 1'b0, 6};
        vecs[3] = '{6'd0,  3'd3, 6'd0,  3'd0, 1'b0, 6};
        vecs[4] = '{6'd17, 3'd0, 6'h3F, 3'd0, 1'b1, 1};
        vecs[5] = '{6'd9,  3'd3, 6'd3,  3'd0, 1'b0, 6};

        #1;
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset quotient", int'(bus.quotient), 0);
        chk("reset remainder", int'(bus.remainder), 0);
        chk("reset dbz", int'(bus.div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d busy after accept", i), int'(bus.busy), 1);
            chk($sformatf("v%0d dbz cleared on accept", i), int'(bus.div_by_zero), 0);
            wait_done(lat);
            chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d quotient", i), int'(bus.quotient), int'(vecs[i].q));
            chk($sformatf("v%0d remainder", i), int'(bus.remainder), int'(vecs[i].r));
            chk($sformatf("v%0d dbz", i), int'(bus.div_by_zero), int'(vecs[i].dbz));
            chk($sformatf("v%0d busy at done", i), int'(bus.busy), 0);
            @(negedge clk);
            chk($sformatf("v%0d done one cycle", i), int'(bus.done), 0);
        end

        // start re-pulsed during CALC must be ignored
        start_op(6'd30, 3'd5);
        @(negedge clk);
        bus.start = 1'b1;
        bus.num1  = 6'd50;
        bus.num2  = 3'd7;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        chk("ignore latency", lat, 4);
        chk("ignore quotient", int'(bus.quotient), 6);
        chk("ignore remainder", int'(bus.remainder), 0);

        // start in the DONE cycle is accepted back-to-back
        bus.start = 1'b1;
        bus.num1  = 6'd50;
        bus.num2  = 3'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b busy", int'(bus.busy), 1);
        chk("b2b done low", int'(bus.done), 0);
        wait_done(lat);
        chk("b2b latency", lat, 6);
        chk("b2b quotient", int'(bus.quotient), 7);
        chk("b2b remainder", int'(bus.remainder), 1);

        // reset in the middle of CALC aborts without a done pulse
        start_op(6'd30, 3'd5);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", int'(bus.busy), 0);
        chk("abort quotient", int'(bus.quotient), 0);
        chk("abort remainder", int'(bus.remainder), 0);
        chk("abort done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk("abort no done", seen, 0);
        start_op(6'd45, 3'd6);
        wait_done(lat);
        chk("post-abort latency", lat, 6);
        chk("post-abort quotient", int'(bus.quotient), 7);
        chk("post-abort remainder", int'(bus.remainder), 3);

        // products of two 3-bit operands divided back by one of them
        for (int a = 1; a < 8; a++) begin
            for (int b = 1; b < 8; b++) begin
                start_op(6'(a * b), 3'(b));
                wait_done(lat);
                tests++;
                if (lat != 6 || int'(bus.quotient) != a || bus.remainder != 0 || bus.div_by_zero) begin
                    fails++;
                    $display("FAIL mult %0d*%0d / %0d: got q=%0d r=%0d dbz=%0d lat=%0d expected q=%0d r=0 dbz=0 lat=6",
                             a, b, b, bus.quotient, bus.remainder, bus.div_by_zero, lat, a);
                end
            end
        end

        // full sweep against the / and % reference
        for (int n = 0; n < 64; n++) begin
            for (int d = 1; d < 8; d++) begin
                start_op(6'(n), 3'(d));
                wait_done(lat);
                tests++;
                if (lat != 6 || int'(bus.quotient) != n / d || int'(bus.remainder) != n % d || bus.div_by_zero) begin
                    fails++;
                    $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dbz=%0d lat=%0d expected q=%0d r=%0d dbz=0 lat=6",
                             n, d, bus.quotient, bus.remainder, bus.div_by_zero, lat, n / d, n % d);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
